ram_task2: RTL and testbench
============================

RAM_TASK2 -- requirements
Module: ram_task2

Interface
REQ-001 Parameter ADDR_W, default 10: address width in bits.
REQ-002 Parameter DATA_W, default 20: word width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W (1024): number of words.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-low (asserted when 0, sampled on the rising edge of clk).
REQ-006 Port we, input, 1: write enable; 1 = write wdata at address on the next rising edge, 0 = read only.
REQ-007 Port address, input, ADDR_W: word address for both read and write.
REQ-008 Port wdata, input, DATA_W: write data.
REQ-009 Port rdata, output, DATA_W: read data for address.

Function
REQ-010 The storage SHALL be a DEPTH x DATA_W array, one word per address, with no byte enables.
REQ-011 The read SHALL be asynchronous.
  - rdata equals the stored word at address, combinationally.
  - Latency is 0 cycles.
  - rdata updates in the same cycle that address changes.
REQ-012 The write SHALL be synchronous: on a rising edge with rst=1 and we=1, mem[address] <= wdata, full DATA_W bits.
REQ-013 When we=0, a rising edge SHALL leave memory contents unchanged.
REQ-014 Read-during-write, same address:
  - Before the edge, rdata shows the old word.
  - After the edge, rdata shows wdata with no extra cycle.
REQ-015 There is no request or ready handshake; the RAM SHALL accept a read or write every cycle. The client treats it as always ready.
REQ-016 Addresses are full-range; all 0..DEPTH-1 are valid, with no wrap-around or out-of-range case.
REQ-017 Unknown or X values on we SHALL NOT be treated as writes in simulation; a write requires we==1.
REQ-018 wdata upper bits SHALL be stored as given. A client using only bits [9:0] sees its data in the low half.

Reset
REQ-019 On a rising edge with rst=0, every location a SHALL be loaded with a, zero-extended to DATA_W.
  - Example: mem[50]=50, mem[67]=67.
  - This completes in that single edge.
REQ-020 Reset SHALL take priority over we; a write coinciding with reset is discarded.
REQ-021 rdata SHALL have no register, so it has no separate reset value. During and after reset it reflects the initialized contents, i.e. rdata == address.
REQ-022 Reset asserted mid-sequence SHALL overwrite all prior writes with the address-pattern initialization.
REQ-023 The array SHALL carry the same address-pattern initial contents at time zero, so simulation before the first reset is defined.

Structure
REQ-024 ADDR_W, DATA_W and DEPTH defaults SHALL live in a shared package. The cache that consumes this RAM imports the same package.
REQ-025 The block SHALL be a single module with no sub-modules.
REQ-026 Storage SHALL be inferable as distributed/LUT RAM with asynchronous read.

Verification
REQ-027 Reset check: hold rst=0 for 2 cycles, release, then read addresses 0, 50, 67, 1023 -> rdata = 0, 50, 67, 1023 in the same cycle.
REQ-028 Write then read: we=1, address=83, wdata=300, one edge; then we=0, address=83 -> rdata=300. Address 82 still reads 82.
REQ-029 Read-during-write: address=95, we=1, wdata=400.
  - Before the edge, rdata=95.
  - After the edge, rdata=400.
REQ-030 Back-to-back writes: write address 100=0xABCDE, then address 101=0x12345 on consecutive edges -> both read back exactly, full 20 bits.
REQ-031 Reset priority and mid-operation reset:
  - Drive rst=0 with we=1, address=50, wdata=777 -> after the edge, rdata=50.
  - Write address 70=777, then reset -> address 70 reads 70.
REQ-032 we=0 hold: vary address and wdata over 10 cycles with we=0 -> no location changes; spot-check 10 addresses equal their index.

Source files
------------

// File: rtl/ram_task2_pkg.sv
// Shared sizing for the task-2 RAM and the cache that sits on top of it.
package ram_task2_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 20;
  localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;

endpackage : ram_task2_pkg

// File: rtl/ram_task2.sv
// Single-port RAM with asynchronous read and synchronous write.
// Reset (and time zero) contents are the address pattern: word a holds a.
//
// The array stores each word XORed with its own zero-extended address.
// With that encoding the address-pattern image is simply all zeros. That
// gives a defined power-up image from a plain declaration initializer, and
// reset becomes a clear. The XOR on each port undoes the encoding, so the
// observable contents are exactly what was written.
module ram_task2
  import ram_task2_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] addr_word;

  // Zero-extended address; this is the word an untouched location reads back.
  always_comb begin
    addr_word = DATA_W'(address);
  end

  // Reset restores the address pattern and overrides any coincident write.
  // Only we==1 writes, so an X on we leaves the array alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[address] <= wdata ^ addr_word;
    end
  end

  // Combinational read with zero latency.
  assign rdata = mem[address] ^ addr_word;

endmodule : ram_task2

// File: tb/tb_ram_task2.sv
// Randomized self-checking bench for ram_task2 against an array model.
module tb_ram_task2;
  import ram_task2_pkg::*;

  localparam int ADDR_W = RAM_ADDR_W;
  localparam int DATA_W = RAM_DATA_W;
  localparam int DEPTH  = RAM_DEPTH;

  logic              clk;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  logic [DATA_W-1:0] model [DEPTH];

  int checks = 0;
  int errors = 0;

  ram_task2 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .address (address),
    .wdata   (wdata),
    .rdata   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (addr %0d)", tag, act, exp, address);
    end
  endtask

  // Model the effect of the coming edge from the rules, then take the edge.
  task automatic step();
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) model[i] = DATA_W'(i);
    end else if (we === 1'b1) begin
      model[address] = wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input int a,
                       input logic [DATA_W-1:0] d);
    rst     = r;
    we      = w;
    address = ADDR_W'(a);
    wdata   = d;
    #1;
  endtask

  task automatic rd(input string tag, input int a, input logic [DATA_W-1:0] exp);
    drive(1'b1, 1'b0, a, '0);
    chk(tag, rdata, exp);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = DATA_W'(i);

    // Contents are defined before any reset.
    drive(1'b1, 1'b0, 37, '0);
    chk("t0_init37", rdata, 20'd37);
    drive(1'b1, 1'b0, 1000, '0);
    chk("t0_init1000", rdata, 20'd1000);

    // Two reset cycles with a write attempted: reset wins.
    drive(1'b0, 1'b1, 50, 20'd777);
    step();
    chk("rst_prio50", rdata, 20'd50);
    step();
    drive(1'b1, 1'b0, 0, '0);

    rd("rst_rd0", 0, 20'd0);
    rd("rst_rd50", 50, 20'd50);
    rd("rst_rd67", 67, 20'd67);
    rd("rst_rd1023", 1023, 20'd1023);

    // Write then read.
    drive(1'b1, 1'b1, 83, 20'd300);
    step();
    rd("wr_rd83", 83, 20'd300);
    rd("wr_rd82", 82, 20'd82);

    // Read during write, same address.
    drive(1'b1, 1'b1, 95, 20'd400);
    chk("rdw_before", rdata, 20'd95);
    step();
    chk("rdw_after", rdata, 20'd400);

    // Back-to-back full-width writes.
    drive(1'b1, 1'b1, 100, 20'hABCDE);
    step();
    drive(1'b1, 1'b1, 101, 20'h12345);
    step();
    rd("b2b_100", 100, 20'hABCDE);
    rd("b2b_101", 101, 20'h12345);

    // Mid-sequence reset wipes earlier writes.
    drive(1'b1, 1'b1, 70, 20'd777);
    step();
    rd("pre_rst70", 70, 20'd777);
    drive(1'b0, 1'b0, 70, '0);
    step();
    chk("mid_rst70", rdata, 20'd70);
    rd("mid_rst83", 83, 20'd83);
    rd("mid_rst100", 100, 20'd100);

    // we=0 for ten cycles with wandering address/data changes nothing.
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b0, int'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom));
      step();
    end
    for (int c = 0; c < 10; c++) begin
      int a;
      a = int'($urandom_range(0, DEPTH - 1));
      rd("hold_spot", a, DATA_W'(a));
    end

    // Random traffic with occasional resets, checked against the model.
    for (int c = 0; c < 300; c++) begin
      drive(($urandom_range(0, 39) != 0), $urandom_range(0, 1) != 0,
            int'($urandom_range(0, 31)) + (($urandom_range(0, 3) == 0) ?
              int'($urandom_range(0, DEPTH - 32)) : 0),
            DATA_W'($urandom));
      chk("rnd_pre", rdata, model[address]);
      step();
      chk("rnd_post", rdata, model[address]);
    end

    // Full sweep of the final contents.
    for (int a = 0; a < DEPTH; a++) begin
      rd("sweep", a, model[a]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ram_task2
